// File: rtl/accum_mc48.sv
// Time-interleaved multi-channel add/subtract/load accumulator with sticky signed
// overflow flags and optional saturation; two-stage pipeline, one beat per cycle.
module accum_mc48 #(
  parameter int unsigned IN_W   = 24,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned SAT_EN = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [CH_W-1:0]   IN_CH,
  input  logic [IN_W-1:0]   A_IN,
  input  logic [IN_W-1:0]   C_IN,
  input  logic              ADD_SUB,
  input  logic              LOAD,
  output logic              OUT_VALID,
  output logic [CH_W-1:0]   OUT_CH,
  output logic [ACC_W-1:0]  ACCUM_OUT,
  output logic [NUM_CH-1:0] OVF
);

  localparam int unsigned EXT_W = ACC_W + 1;

  logic              accept_c;
  logic              s1_valid;
  logic [CH_W-1:0]   s1_ch;
  logic [ACC_W-1:0]  s1_op;
  logic              s1_sub;
  logic              s1_load;

  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [ACC_W-1:0]  acc_rd_c;
  logic [EXT_W-1:0]  ext_acc_c;
  logic [EXT_W-1:0]  ext_op_c;
  logic [EXT_W-1:0]  sum_c;
  logic              ovf_c;
  logic [ACC_W-1:0]  res_c;

  // Beats addressing a non-existent channel are dropped at the input.
  assign accept_c = IN_VALID && (32'(IN_CH) < NUM_CH);

  // Read the addressed accumulator; stage 2 writes land before the next read.
  always_comb begin
    acc_rd_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s1_ch == CH_W'(i)) acc_rd_c = acc[i];
    end
  end

  // Sign-extended add/sub; overflow when the extra sign bit disagrees.
  always_comb begin
    ext_acc_c = {acc_rd_c[ACC_W-1], acc_rd_c};
    ext_op_c  = {s1_op[ACC_W-1], s1_op};
    sum_c     = s1_sub ? (ext_acc_c - ext_op_c) : (ext_acc_c + ext_op_c);
    ovf_c     = !s1_load && (sum_c[ACC_W] != sum_c[ACC_W-1]);
    res_c     = sum_c[ACC_W-1:0];
    if (s1_load) begin
      res_c = s1_op;
    end else if (ovf_c && (SAT_EN != 0)) begin
      res_c = sum_c[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Stage 1 capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_op    <= '0;
      s1_sub   <= 1'b0;
      s1_load  <= 1'b0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_ch   <= IN_CH;
        s1_op   <= ACC_W'({A_IN, C_IN});
        s1_sub  <= ADD_SUB;
        s1_load <= LOAD;
      end
    end
  end

  // Stage 2 write-back, sticky overflow and registered result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      OUT_CH    <= '0;
      ACCUM_OUT <= '0;
      OVF       <= '0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else begin
      OUT_VALID <= s1_valid;
      if (s1_valid) begin
        OUT_CH    <= s1_ch;
        ACCUM_OUT <= res_c;
        for (int i = 0; i < NUM_CH; i++) begin
          if (s1_ch == CH_W'(i)) begin
            acc[i] <= res_c;
            if (s1_load)    OVF[i] <= 1'b0;
            else if (ovf_c) OVF[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_mc48.sv
// Scoreboard bench for accum_mc48: default instance (saturating, 4 channels) and a
// wrapping 3-channel instance.
module tb_accum_mc48;

  typedef struct {
    logic [1:0]  ch;
    logic [47:0] val;
    int          cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  logic        v0 = 1'b0, sub0 = 1'b0, ld0 = 1'b0;
  logic [1:0]  ch0 = '0;
  logic [23:0] a0 = '0, c0 = '0;
  logic        ov0;
  logic [1:0]  och0;
  logic [47:0] acc0;
  logic [3:0]  ovf0;

  logic        v1 = 1'b0, sub1 = 1'b0, ld1 = 1'b0;
  logic [1:0]  ch1 = '0;
  logic [23:0] a1 = '0, c1 = '0;
  logic        ov1;
  logic [1:0]  och1;
  logic [47:0] acc1;
  logic [2:0]  ovf1;

  accum_mc48 u_dut (
    .CLK(CLK), .RST(RST), .IN_VALID(v0), .IN_CH(ch0), .A_IN(a0), .C_IN(c0),
    .ADD_SUB(sub0), .LOAD(ld0), .OUT_VALID(ov0), .OUT_CH(och0),
    .ACCUM_OUT(acc0), .OVF(ovf0)
  );

  accum_mc48 #(.NUM_CH(3), .SAT_EN(0)) u_wrap (
    .CLK(CLK), .RST(RST), .IN_VALID(v1), .IN_CH(ch1), .A_IN(a1), .C_IN(c1),
    .ADD_SUB(sub1), .LOAD(ld1), .OUT_VALID(ov1), .OUT_CH(och1),
    .ACCUM_OUT(acc1), .OVF(ovf1)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic beat0(input logic [1:0] ch, input logic [23:0] a, input logic [23:0] c,
                       input logic sub, input logic ld, input bit push, input logic [47:0] expv);
    @(negedge CLK);
    v0 = 1'b1; ch0 = ch; a0 = a; c0 = c; sub0 = sub; ld0 = ld;
    if (push) q0.push_back('{ch, expv, cyc + 2});
  endtask

  task automatic beat1(input logic [1:0] ch, input logic [23:0] a, input logic [23:0] c,
                       input logic sub, input logic ld, input bit push, input logic [47:0] expv);
    @(negedge CLK);
    v1 = 1'b1; ch1 = ch; a1 = a; c1 = c; sub1 = sub; ld1 = ld;
    if (push) q1.push_back('{ch, expv, cyc + 2});
  endtask

  task automatic drain();
    @(negedge CLK);
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  // Monitors: every OUT_VALID pulse must match the oldest expectation, including its cycle.
  always @(negedge CLK) begin
    if (ov0) begin
      exp_t e;
      checks++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL out0_unexpected: ch=%0d val=%h cyc=%0d", och0, acc0, cyc);
      end else begin
        e = q0.pop_front();
        if (och0 !== e.ch || acc0 !== e.val || cyc != e.cyc) begin
          fails++;
          $display("FAIL out0: got ch=%0d val=%h cyc=%0d expected ch=%0d val=%h cyc=%0d",
                   och0, acc0, cyc, e.ch, e.val, e.cyc);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (ov1) begin
      exp_t e;
      checks++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL out1_unexpected: ch=%0d val=%h cyc=%0d", och1, acc1, cyc);
      end else begin
        e = q1.pop_front();
        if (och1 !== e.ch || acc1 !== e.val || cyc != e.cyc) begin
          fails++;
          $display("FAIL out1: got ch=%0d val=%h cyc=%0d expected ch=%0d val=%h cyc=%0d",
                   och1, acc1, cyc, e.ch, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge CLK);
    chk("reset_out_valid", 64'(ov0), 64'h0);
    chk("reset_accum", 64'(acc0), 64'h0);
    chk("reset_ovf", 64'(ovf0), 64'h0);
    RST = 1'b0;

    // Mid-stream reset: first beat completes, second is in flight and must vanish.
    beat0(2'd0, 24'h123456, 24'h654321, 1'b0, 1'b1, 1'b1, 48'h123456654321);
    beat0(2'd1, 24'h000001, 24'h000001, 1'b0, 1'b1, 1'b0, 48'h0);
    @(negedge CLK);
    v0 = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_out_valid", 64'(ov0), 64'h0);
    chk("midrst_accum", 64'(acc0), 64'h0);
    chk("midrst_ovf", 64'(ovf0), 64'h0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("midrst_no_stale", 64'(ov0), 64'h0);
    beat0(2'd0, 24'h0, 24'h1, 1'b0, 1'b0, 1'b1, 48'h000000000001);
    drain();

    // ch0 load then back-to-back adds.
    beat0(2'd0, 24'd512, 24'd514, 1'b0, 1'b1, 1'b1, 48'h000200000202);
    beat0(2'd0, 24'd512, 24'd514, 1'b0, 1'b0, 1'b1, 48'h000400000404);
    beat0(2'd0, 24'd512, 24'd514, 1'b0, 1'b0, 1'b1, 48'h000600000606);
    // ch1 load then subtract, ch0 untouched.
    beat0(2'd1, 24'd2020, 24'd2000, 1'b0, 1'b1, 1'b1, 48'h0007E40007D0);
    beat0(2'd1, 24'd10, 24'd14, 1'b1, 1'b0, 1'b1, 48'h0007DA0007C2);
    beat0(2'd0, 24'd0, 24'd0, 1'b0, 1'b0, 1'b1, 48'h000600000606);
    drain();
    chk("ovf_clean", 64'(ovf0), 64'h0);

    // Positive saturation on ch2, sticky flag, cleared by load.
    beat0(2'd2, 24'h7FFFFF, 24'hFFFFF0, 1'b0, 1'b1, 1'b1, 48'h7FFFFFFFFFF0);
    beat0(2'd2, 24'h0, 24'h20, 1'b0, 1'b0, 1'b1, 48'h7FFFFFFFFFFF);
    beat0(2'd2, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1, 48'h7FFFFFFFFFFF);
    drain();
    chk("sat_pos_ovf", 64'(ovf0), 64'h4);
    beat0(2'd2, 24'h0, 24'h0, 1'b0, 1'b1, 1'b1, 48'h0);
    drain();
    chk("load_clears_ovf", 64'(ovf0), 64'h0);

    // Subtracting the most negative operand from zero saturates positive.
    beat0(2'd3, 24'h0, 24'h0, 1'b0, 1'b1, 1'b1, 48'h0);
    beat0(2'd3, 24'h800000, 24'h0, 1'b1, 1'b0, 1'b1, 48'h7FFFFFFFFFFF);
    beat0(2'd1, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1, 48'h0007DA0007C2);
    drain();
    chk("sat_neg_op_ovf", 64'(ovf0), 64'h8);

    // Wrapping instance: same overflow stimulus keeps the wrapped value.
    beat1(2'd2, 24'h0, 24'h0, 1'b0, 1'b1, 1'b1, 48'h0);
    beat1(2'd2, 24'h800000, 24'h0, 1'b1, 1'b0, 1'b1, 48'h800000000000);
    drain();
    chk("wrap_ovf", 64'(ovf1), 64'h4);

    // Out-of-range channel between valid beats is dropped without side effects.
    beat1(2'd0, 24'h0, 24'h5, 1'b0, 1'b1, 1'b1, 48'h000000000005);
    beat1(2'd3, 24'h0, 24'h0, 1'b0, 1'b1, 1'b0, 48'h0);
    beat1(2'd0, 24'h0, 24'h1, 1'b0, 1'b0, 1'b1, 48'h000000000006);
    beat1(2'd3, 24'h111111, 24'h0, 1'b1, 1'b0, 1'b0, 48'h0);
    beat1(2'd2, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1, 48'h800000000000);
    beat1(2'd1, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1, 48'h0);
    drain();
    chk("drop_ovf_unchanged", 64'(ovf1), 64'h4);
    chk("drop_hold_ch", 64'(och1), 64'h1);

    chk("q0_drained", 64'(q0.size()), 64'h0);
    chk("q1_drained", 64'(q1.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
